inst_encoder_loader: RTL

Sequential program loader for the single-cycle RISC-V core. It is the encoding side of the core's instruction decoder. It accepts one instruction per handshake as decoded fields (format, func3, func7, registers, immediate) and packs them into a 32-bit RV32I word. Legal words are written into instruction memory at consecutive word addresses. Used by the bench and boot path to fill instruction memory before the core runs.

---
 rtl/rv_isa_pkg.sv | 64 ++++++
 rtl/rv_inst_pack.sv | 71 +++++++
 rtl/inst_encoder_loader.sv | 113 +++++++++++
 3 files changed

// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants for the instruction encoder/loader.
// Holds opcodes (the same values the decoder matches), the loader's `kind`
// encodings, func3/func7 values of the supported subset, immediate bounds,
// and the request struct handed to the field packer.
package rv_isa_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [2:0] {
    K_R    = 3'd0,
    K_I    = 3'd1,
    K_S    = 3'd2,
    K_B    = 3'd3,
    K_U    = 3'd4,
    K_J    = 3'd5,
    K_LW   = 3'd6,
    K_JALR = 3'd7
  } kind_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMMB_MIN  = -4096;
  localparam int IMMB_MAX  = 4094;
  localparam int IMMJ_MIN  = -1048576;
  localparam int IMMJ_MAX  = 1048574;

  typedef struct packed {
    kind_e       kind;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } inst_req_t;

  function automatic logic imm_in_range(logic [31:0] imm, int lo, int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/rv_inst_pack.sv
// Combinational RV32I field packer with legality check.
//   req   : decoded instruction fields (kind, func3, func7, rd, rs1, rs2, imm)
//   word  : packed 32-bit instruction; fields unused by the format are 0
//   legal : func3/func7 is in the supported subset and imm is in range
module rv_inst_pack
  import rv_isa_pkg::*;
(
  input  inst_req_t   req,
  output logic [31:0] word,
  output logic        legal
);

  logic [31:0] imm;
  logic        f3_ok;
  logic        imm_ok;

  assign imm = req.imm;

  always_comb begin
    word   = '0;
    f3_ok  = 1'b0;
    imm_ok = 1'b1;
    case (req.kind)
      K_R: begin
        word  = {req.func7, req.rs2, req.rs1, req.func3, req.rd, OP_R};
        f3_ok = ((req.func7 == F7_BASE) &&
                 (req.func3 inside {F3_ADD, F3_AND, F3_OR, F3_SLT})) ||
                ((req.func7 == F7_SUB) && (req.func3 == F3_ADD));
      end
      K_I: begin
        word   = {imm[11:0], req.rs1, req.func3, req.rd, OP_I};
        f3_ok  = req.func3 inside {F3_ADD, F3_XOR, F3_OR, F3_SLT};
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_LW: begin
        word   = {imm[11:0], req.rs1, req.func3, req.rd, OP_LW};
        f3_ok  = req.func3 == F3_LW;
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_JALR: begin
        word   = {imm[11:0], req.rs1, req.func3, req.rd, OP_JALR};
        f3_ok  = req.func3 == F3_JALR;
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_S: begin
        word   = {imm[11:5], req.rs2, req.rs1, req.func3, imm[4:0], OP_S};
        f3_ok  = req.func3 == F3_SW;
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      K_B: begin
        word   = {imm[12], imm[10:5], req.rs2, req.rs1, req.func3,
                  imm[4:1], imm[11], OP_B};
        f3_ok  = req.func3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE};
        imm_ok = imm_in_range(imm, IMMB_MIN, IMMB_MAX) && !imm[0];
      end
      K_U: begin
        // Upper immediate is taken as-is; low 12 bits are simply not encoded.
        word  = {imm[31:12], req.rd, OP_U};
        f3_ok = 1'b1;
      end
      K_J: begin
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OP_J};
        f3_ok  = 1'b1;
        imm_ok = imm_in_range(imm, IMMJ_MIN, IMMJ_MAX) && !imm[0];
      end
    endcase
  end

  assign legal = f3_ok && imm_ok;

endmodule

// File: rtl/inst_encoder_loader.sv
// Sequential program loader: encodes one instruction per handshake and
// writes legal words to instruction memory at consecutive word addresses.
//   clk, rst            : clock, synchronous active-high reset
//   restart, base_addr  : reload write pointer and clear count (IDLE only)
//   in_valid/in_ready   : field handshake; kind/func3/func7/rd/rs1/rs2/imm
//   mem_we/mem_ready    : write request held until memory accepts it
//   mem_addr, mem_wdata : registered write address / encoded word
//   inst_count, full    : words written since reset/restart, count == DEPTH
//   err                 : one-cycle pulse after an illegal request is dropped
module inst_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 32,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CW-1:0]     inst_count,
  output logic              full,
  output logic              err
);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e            state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [CW-1:0]     count;
  logic              accept;
  logic              done;
  inst_req_t         req;
  logic [31:0]       word;
  logic              legal;

  assign req = '{kind: kind_e'(kind), func3: func3, func7: func7,
                 rd: rd, rs1: rs1, rs2: rs2, imm: imm};

  rv_inst_pack u_pack (
    .req   (req),
    .word  (word),
    .legal (legal)
  );

  assign full       = (count == CW'(DEPTH));
  assign inst_count = count;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    accept   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        // restart takes the cycle, so no request can be taken alongside it
        in_ready = !full && !restart;
        accept   = in_valid && in_ready;
        if (accept && legal) state_d = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        done   = mem_ready;
        if (mem_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !legal;
      if (state == IDLE && restart) begin
        ptr   <= base_addr;
        count <= '0;
      end
      // Illegal requests also latch word/address, but mem_we stays low.
      if (accept) begin
        mem_addr  <= ptr;
        mem_wdata <= word;
      end
      if (done) begin
        ptr   <= ptr + ADDR_W'(4);
        count <= count + CW'(1);
      end
    end
  end

endmodule
